// File: rtl/bj_resolve_ctrl.sv
// ID-stage branch resolve sequencer: counts hazard stalls, samples ben once, issues held redirect.
// Optional statistics counters are built when BJ_STATS_EN is defined.
module bj_resolve_ctrl #(
  parameter int STALL_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [31:0]      id_target,
  input  logic             ex_wr,
  input  logic [4:0]       ex_wr_reg,
  input  logic             ex_load,
  input  logic             mem_wr,
  input  logic [4:0]       mem_wr_reg,
  input  logic             mem_load,
  input  logic             ben,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic             bj_stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stat_branch,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [STALL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_redirect;
  logic [31:0]        r_redirect_pc;
  logic               w_br, w_ex_match, w_mem_match, w_resolve, w_stall;
  logic [1:0]         w_need;

  function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign w_br        = id_valid & id_branch & ~flush;
  assign w_ex_match  = f_match(ex_wr_reg, id_rs, id_rt, id_uses_rt);
  assign w_mem_match = f_match(mem_wr_reg, id_rs, id_rt, id_uses_rt);

  // MEM ALU results reach the comparator through forwarding, so only MEM loads stall.
  always_comb begin
    w_need = 2'd0;
    if (ex_wr && ex_load && w_ex_match)         w_need = 2'd2;
    else if (ex_wr && w_ex_match)               w_need = 2'd1;
    else if (mem_wr && mem_load && w_mem_match) w_need = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_br && !pipe_hold) begin
            if (w_need == 2'd0) begin
              w_resolve = 1'b1;
            end else begin
              w_stall = 1'b1;
              if (w_need == 2'd1) begin
                w_state_nxt = S_RESOLVE;
              end else begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = STALL_W'(w_need - 2'd1);
              end
            end
          end
        end
        S_WAIT: begin
          w_stall = 1'b1;
          if (!pipe_hold) begin
            w_cnt_nxt = r_cnt - STALL_W'(1);
            if (r_cnt == STALL_W'(1)) w_state_nxt = S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (!pipe_hold) begin
            w_resolve   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Redirect is held across a frozen pipeline so fetch cannot miss it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else if (flush) begin
      r_redirect <= 1'b0;
    end else if (w_resolve && ben) begin
      r_redirect    <= 1'b1;
      r_redirect_pc <= id_target;
    end else if (!pipe_hold) begin
      r_redirect <= 1'b0;
    end
  end

  assign bj_stall    = w_stall;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;

`ifdef BJ_STATS_EN
  logic [CNT_W-1:0] r_stat_branch, r_stat_taken, r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branch <= '0;
      r_stat_taken  <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_resolve)              r_stat_branch <= r_stat_branch + CNT_W'(1);
      if (w_resolve && ben)       r_stat_taken  <= r_stat_taken + CNT_W'(1);
      if (w_stall && !pipe_hold)  r_stat_stall  <= r_stat_stall + CNT_W'(1);
    end
  end

  assign stat_branch = r_stat_branch;
  assign stat_taken  = r_stat_taken;
  assign stat_stall  = r_stat_stall;
`else
  assign stat_branch = '0;
  assign stat_taken  = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_bj_resolve_ctrl.sv
// Directed + randomized bench for bj_resolve_ctrl against a stall-budget reference model.
module tb_bj_resolve_ctrl;
  localparam int CNT_W = 32;

  logic             clk, reset;
  logic             id_valid, id_branch, id_uses_rt, ex_wr, ex_load, mem_wr, mem_load;
  logic             ben, pipe_hold, flush;
  logic [4:0]       id_rs, id_rt, ex_wr_reg, mem_wr_reg;
  logic [31:0]      id_target;
  logic             bj_stall, redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stat_branch, stat_taken, stat_stall;

  bj_resolve_ctrl #(.STALL_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_target(id_target),
    .ex_wr(ex_wr), .ex_wr_reg(ex_wr_reg), .ex_load(ex_load),
    .mem_wr(mem_wr), .mem_wr_reg(mem_wr_reg), .mem_load(mem_load),
    .ben(ben), .pipe_hold(pipe_hold), .flush(flush),
    .bj_stall(bj_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branch(stat_branch), .stat_taken(stat_taken), .stat_stall(stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, obs_stalls = 0;

  // Reference model: a branch in ID owes a number of stall cycles, then resolves on the
  // first unfrozen cycle once the debt is paid.
  bit          m_act;
  int          m_rem;
  logic        m_redir;
  logic [31:0] m_pc, m_sb, m_st, m_ss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit hz(input logic [4:0] r);
    return (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt));
  endfunction

  function automatic int need_n();
    if (ex_wr && ex_load && hz(ex_wr_reg)) return 2;
    if (ex_wr && hz(ex_wr_reg)) return 1;
    if (mem_wr && mem_load && hz(mem_wr_reg)) return 1;
    return 0;
  endfunction

  task automatic set_idle();
    id_valid = 0; id_branch = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_target = 0;
    ex_wr = 0; ex_wr_reg = 0; ex_load = 0; mem_wr = 0; mem_wr_reg = 0; mem_load = 0;
    ben = 0; pipe_hold = 0; flush = 0;
  endtask

  task automatic set_br(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [31:0] tgt, input logic b);
    id_valid = 1; id_branch = 1; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_target = tgt; ben = b;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_redir"}, {31'd0, redirect}, {31'd0, m_redir});
    check({tag, "_pc"}, redirect_pc, m_pc);
`ifdef BJ_STATS_EN
    check({tag, "_sbr"}, stat_branch, m_sb);
    check({tag, "_stk"}, stat_taken, m_st);
    check({tag, "_sst"}, stat_stall, m_ss);
`else
    check({tag, "_sbr"}, stat_branch, 32'd0);
    check({tag, "_stk"}, stat_taken, 32'd0);
    check({tag, "_sst"}, stat_stall, 32'd0);
`endif
  endtask

  // Called just after a falling edge with inputs applied; ends at the next falling edge.
  task automatic step(input string tag);
    bit br, es, res;
    int n;
    #1;
    br = id_valid && id_branch && !flush;
    es = 0; res = 0;
    if (flush) begin
      m_act = 0; m_rem = 0;
    end else if (!m_act) begin
      if (br && !pipe_hold) begin
        n = need_n();
        if (n > 0) begin es = 1; m_act = 1; m_rem = n - 1; end
        else res = 1;
      end
    end else if (m_rem > 0) begin
      es = 1;
      if (!pipe_hold) m_rem--;
    end else if (!pipe_hold) begin
      res = 1; m_act = 0;
    end
    check({tag, "_stall"}, {31'd0, bj_stall}, {31'd0, es});
    if (bj_stall === 1'b1) obs_stalls++;
    if (es && !pipe_hold) m_ss++;
    if (res) begin m_sb++; if (ben) m_st++; end
    if (flush) m_redir = 0;
    else if (res && ben) begin m_redir = 1; m_pc = id_target; end
    else if (!pipe_hold) m_redir = 0;
    @(posedge clk); #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 0;
    m_act = 0; m_rem = 0; m_redir = 0; m_pc = 0; m_sb = 0; m_st = 0; m_ss = 0;
    #1;
    check("rst_stall", {31'd0, bj_stall}, 32'd0);
    check_regs("rst");
  endtask

  initial begin
    reset = 1;
    set_idle();
    do_reset();

    // no-hazard beq, taken
    set_br(5'd5, 5'd5, 1, 32'h0040_0100, 1);
    step("nohaz");
    check("nohaz_pc_const", redirect_pc, 32'h0040_0100);
    check("nohaz_redir_const", {31'd0, redirect}, 32'd1);
    set_idle(); step("nohaz_after");
    check("nohaz_clear_const", {31'd0, redirect}, 32'd0);

    // bne with ALU producer in EX: one stall, not taken
    obs_stalls = 0;
    set_br(5'd8, 5'd2, 1, 32'h0040_0200, 0);
    ex_wr = 1; ex_wr_reg = 5'd8;
    step("alu_ex0"); step("alu_ex1");
    check("alu_ex_stalls", obs_stalls, 32'd1);
    set_idle(); step("alu_ex_idle");

    // load in EX writing rt: two stalls, taken
    obs_stalls = 0;
    set_br(5'd3, 5'd9, 1, 32'h0040_0300, 1);
    ex_wr = 1; ex_load = 1; ex_wr_reg = 5'd9;
    step("ld_ex0"); step("ld_ex1"); step("ld_ex2");
    check("ld_ex_stalls", obs_stalls, 32'd2);
    check("ld_ex_redir_const", {31'd0, redirect}, 32'd1);
    set_idle(); step("ld_ex_idle");

    // load writing $0, then bgtz ignoring rt
    obs_stalls = 0;
    set_br(5'd0, 5'd0, 1, 32'h0040_0400, 0);
    ex_wr = 1; ex_load = 1; ex_wr_reg = 5'd0;
    step("zero_reg");
    set_br(5'd3, 5'd9, 0, 32'h0040_0500, 1);
    ex_wr = 1; ex_load = 1; ex_wr_reg = 5'd9;
    step("bgtz");
    check("bgtz_stalls", obs_stalls, 32'd0);
    check("bgtz_pc_const", redirect_pc, 32'h0040_0500);
    set_idle(); step("bgtz_idle");

    // load-use with a 3-cycle freeze inside WAIT, redirect held under freeze
    obs_stalls = 0;
    set_br(5'd4, 5'd1, 1, 32'h0040_0600, 1);
    ex_wr = 1; ex_load = 1; ex_wr_reg = 5'd4;
    step("hold0");
    pipe_hold = 1; step("hold1"); step("hold2"); step("hold3");
    pipe_hold = 0; step("hold4"); step("hold5");
    check("hold_stalls", obs_stalls, 32'd5);
    set_idle(); pipe_hold = 1; step("hold_keep");
    check("hold_keep_const", {31'd0, redirect}, 32'd1);
    pipe_hold = 0; step("hold_rel");

    // flush during WAIT
    set_br(5'd6, 5'd7, 1, 32'h0040_0700, 1);
    ex_wr = 1; ex_load = 1; ex_wr_reg = 5'd7;
    step("fl0");
    flush = 1; step("fl1");
    set_idle(); step("fl2");
    check("fl_redir_const", {31'd0, redirect}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      id_valid   = ($urandom_range(4) != 0);
      id_branch  = ($urandom_range(4) > 1);
      id_rs      = 5'($urandom_range(3));
      id_rt      = 5'($urandom_range(3));
      id_uses_rt = 1'($urandom_range(1));
      id_target  = $urandom;
      ex_wr      = 1'($urandom_range(1));
      ex_load    = 1'($urandom_range(1));
      ex_wr_reg  = 5'($urandom_range(3));
      mem_wr     = 1'($urandom_range(1));
      mem_load   = 1'($urandom_range(1));
      mem_wr_reg = 5'($urandom_range(3));
      ben        = 1'($urandom_range(1));
      pipe_hold  = ($urandom_range(3) == 0);
      flush      = ($urandom_range(15) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bj_resolve_ctrl.md
Name: bj_resolve_ctrl

Overview:
- Sequences ID-stage branch resolution around the branch comparator.
- Detects operand hazards against EX/MEM, then stalls ID for an exact, counted number of cycles.
- Samples the comparator's taken flag at the single resolve cycle and issues a held redirect to fetch.
- Sits between the decoder, the hazard/forwarding logic and the PC-select mux.

Parameters:
- STALL_W, 2, width of the stall-cycle counter (max stall 3).
- CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a valid instruction.
- id_branch  input  1  ID instruction is a conditional branch.
- id_rs  input  5  source register rs of the ID instruction.
- id_rt  input  5  source register rt of the ID instruction.
- id_uses_rt  input  1  branch compares rt (beq/bne); 0 for rs-only forms.
- id_target  input  32  computed branch target.
- ex_wr  input  1  EX instruction writes a GPR.
- ex_wr_reg  input  5  EX destination register.
- ex_load  input  1  EX instruction is a load.
- mem_wr  input  1  MEM instruction writes a GPR.
- mem_wr_reg  input  5  MEM destination register.
- mem_load  input  1  MEM instruction is a load.
- ben  input  1  comparator taken result on forwarded operands.
- pipe_hold  input  1  global pipeline freeze (mult/div, memory).
- flush  input  1  kill the ID instruction (exception/eret).
- bj_stall  output  1  freeze IF/ID and insert an EX bubble.
- redirect  output  1  fetch must load redirect_pc.
- redirect_pc  output  32  taken target.
- stat_branch  output  CNT_W  resolved branches (optional feature).
- stat_taken  output  CNT_W  taken branches (optional feature).
- stat_stall  output  CNT_W  branch stall cycles (optional feature).

Behaviour:
- Reset: state=IDLE, cnt=0, redirect=0, redirect_pc=0, all stat counters=0. bj_stall=0 after reset.
- br = id_valid & id_branch & ~flush.
- match(r) means r!=0 and (r==id_rs, or id_uses_rt and r==id_rt).
- Required stall count N, first rule wins:
  - ex_wr & ex_load & match(ex_wr_reg): N=2.
  - ex_wr & match(ex_wr_reg): N=1.
  - mem_wr & mem_load & match(mem_wr_reg): N=1.
  - otherwise: N=0 (MEM ALU results are forwarded).
- States: IDLE, WAIT, RESOLVE.
- IDLE:
  - If br & ~pipe_hold & N>0: bj_stall=1. If N==1, go to RESOLVE. If N==2, go to WAIT with cnt<=1.
  - If br & ~pipe_hold & N==0: this is the resolve cycle; state stays IDLE.
  - If pipe_hold: nothing is evaluated.
- WAIT:
  - bj_stall=1.
  - If ~pipe_hold: cnt<=cnt-1; when cnt==1, go to RESOLVE.
  - If pipe_hold: cnt and state are frozen, bj_stall stays 1.
- RESOLVE:
  - bj_stall=0. N is not re-evaluated.
  - If ~pipe_hold, this is the resolve cycle; go to IDLE.
  - If pipe_hold, stay in RESOLVE.
- Resolve cycle: ben is sampled.
  - If ben=1: redirect<=1 and redirect_pc<=id_target on the next edge (1-cycle latency). The delay slot is fetched normally.
  - If ben=0: no redirect.
- Redirect hold: redirect stays 1 until an edge with pipe_hold=0, then clears. A new resolve cannot occur while redirect=1 and pipe_hold=1, because the pipeline is frozen.
- flush: a synchronous override. State<=IDLE, cnt<=0, redirect<=0, bj_stall=0 in that cycle, and no resolve.
- reset has priority over flush; both are synchronous.
- Register $0 never causes a hazard.
- Back-to-back branches (the second in the delay slot) are each resolved independently.
- A non-branch instruction in ID leaves the state in IDLE and bj_stall=0.

Optional Feature:
- Macro: BJ_STATS_EN.
- Defined:
  - stat_branch increments on each resolve cycle.
  - stat_taken increments on each resolve cycle with ben=1.
  - stat_stall increments on each cycle with bj_stall=1 & ~pipe_hold.
  - All three wrap modulo 2^CNT_W and are cleared by reset only (not by flush).
- Undefined: the counter logic is absent and the stat_* ports are tied to 0.

Test Plan:
- No-hazard beq, rs=rt=5, ben=1, id_target=0x00400100 -> bj_stall never 1; next cycle redirect=1, redirect_pc=0x00400100; the following cycle redirect=0.
- bne with ALU in EX writing id_rs=8, ben=0 -> bj_stall=1 for exactly 1 cycle; RESOLVE next cycle; redirect stays 0.
- beq with load in EX writing id_rt=9, id_uses_rt=1, ben=1 -> bj_stall=1 for 2 cycles (IDLE, WAIT); redirect=1 on the cycle after RESOLVE.
- Load in EX writing $0, or writing rt with id_uses_rt=0 (bgtz) -> no stall; bgtz with ben=1 redirects after 1 cycle.
- Load-use stall with pipe_hold=1 for 3 cycles inside WAIT -> bj_stall=1 for 5 cycles total, cnt frozen during the hold; redirect held high while pipe_hold=1 at issue.
- flush asserted during WAIT -> that cycle bj_stall=0, state IDLE, no redirect. With BJ_STATS_EN, after 4 resolved branches (3 taken, 3 stall cycles): stat_branch=4, stat_taken=3, stat_stall=3.
